vsharp_struct_assembler_fsm: RTL and testbench
==============================================

Name: vsharp_struct_assembler_fsm

Overview:
- Parametrised struct-loading state machine in the VSharp generated-FSM style.
- Accepts a struct one field per transfer, each field with a tag.
- Checks every tag against the expected field index.
- Presents the fully assembled struct on a single wide output with a valid/ready handshake.
- Generalises the single-field load-then-present FSM to N fields of configurable width, adding backpressure and type-check error reporting.

Parameters:
- FIELD_W, 32, width of one struct field in bits.
- NUM_FIELDS, 3, number of fields per struct (>=1).
- TAG_W, max(1, clog2(NUM_FIELDS)), tag width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  FIELD_W  field payload.
- in_tag  input  TAG_W  field index the producer claims for in_data.
- in_valid  input  1  producer has a field.
- in_ready  output  1  block accepts a field this cycle.
- out_struct  output  FIELD_W*NUM_FIELDS  assembled struct; field k at bits [k*FIELD_W +: FIELD_W].
- out_valid  output  1  out_struct holds a complete struct.
- out_ready  input  1  consumer takes the struct.
- err  output  1  sticky tag-mismatch flag.
- err_field  output  TAG_W  expected index at the time of the mismatch.
- err_clear  input  1  leave ERROR state.
- fsm_state  output  8  current state encoding, for debug and monitoring.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. All registers clear immediately on reset, without waiting for a clock edge.
- Reset values:
  - fsm_state=0 (INITIAL), in_ready=0, out_valid=0, out_struct=0.
  - err=0, err_field=0.
  - Internal field index idx=0; staging register=0.
- State encoding (8-bit): INITIAL=0, LOAD=1, EMIT=2, ERROR=3. Other values are unreachable; if one is decoded, the FSM goes to INITIAL.
- Handshake: a transfer occurs on any rising edge where valid and ready are both high.
- INITIAL: lasts one cycle. Clears idx and the staging register, then goes to LOAD. in_ready=0.
- LOAD: in_ready=1, out_valid=0. On an input transfer:
  - Tag matches (in_tag==idx): staging field[idx] <= in_data.
    - If idx==NUM_FIELDS-1: out_struct <= full staging value including this field, idx <= 0, go to EMIT.
    - Otherwise idx <= idx+1.
  - Tag mismatches: in_data is discarded; err <= 1, err_field <= idx, go to ERROR.
- EMIT: out_valid=1, in_ready=0. On out_ready, go to LOAD; out_valid is low from the next cycle.
- ERROR: in_ready=0, out_valid=0, err held high.
  - err_clear=1 → err <= 0, go to INITIAL. err_field keeps its value until the next error or reset.
  - err_clear is ignored in all other states.
- Latency: out_valid rises on the cycle after the last field is accepted. Minimum period per struct is NUM_FIELDS+1 cycles when out_ready is held high.
- out_struct changes only when a struct completes. Partial loads are never visible on it. out_struct keeps its last value after the handshake and after ERROR.
- in_valid while in_ready=0 (INITIAL/EMIT/ERROR): ignored; the producer must hold its data.
- Reset mid-LOAD or mid-EMIT: the partial or pending struct is lost; the FSM restarts from INITIAL.
- NUM_FIELDS=1: TAG_W=1. Only tag 0 is valid; every accepted field completes a struct.
- Tag values >= NUM_FIELDS are always a mismatch.

Test Plan:
(FIELD_W=32, NUM_FIELDS=3 unless noted)
1. Basic assembly:
   - Stimulus: after reset, send {tag0:32'd123, tag1:32'hDEADBEEF, tag2:32'h1} back-to-back, out_ready=1.
   - Required: out_valid high for exactly 1 cycle, starting one cycle after the tag2 transfer. out_struct=96'h00000001_DEADBEEF_0000007B. fsm_state sequence 0,1,1,1,2,1.
2. Backpressure:
   - Stimulus: as test 1 with out_ready=0 for 5 cycles.
   - Required: out_valid and out_struct stable for those 5 cycles; in_ready=0 throughout; fourth field (tag0:32'hAA) is not accepted until after the handshake.
3. Tag mismatch:
   - Stimulus: send tag0:32'h5, then tag2:32'h7.
   - Required: err=1, err_field=1, fsm_state=3, in_ready=0, out_struct unchanged (0). Pulse err_clear → err=0, fsm_state 0 then 1; a new full struct assembles correctly.
4. Out-of-range tag:
   - Stimulus: first field carries tag=3.
   - Required: ERROR with err_field=0.
5. Asynchronous reset mid-load:
   - Stimulus: after two fields are accepted, assert reset between clock edges.
   - Required: all outputs go to reset values immediately (before the next edge). After release, the FSM needs three fresh fields; the stale fields never appear on out_struct.
6. NUM_FIELDS=1, FIELD_W=8:
   - Stimulus: stream tag0 values 8'h11, 8'h22 with out_ready=1.
   - Required: out_struct=8'h11 then 8'h22, with one out_valid pulse per value, each 2 cycles apart.

Source files
------------

// File: rtl/vsharp_struct_assembler_fsm_if.sv
// Field-in / struct-out bus of the struct assembler, plus error and debug status.
// The master drives fields in and takes structs out; the slave is the assembler.
interface vsharp_struct_assembler_fsm_if #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 3
);
    localparam int TAG_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int STRUCT_W = FIELD_W * NUM_FIELDS;

    logic [FIELD_W-1:0]  in_data;
    logic [TAG_W-1:0]    in_tag;
    logic                in_valid;
    logic                in_ready;
    logic [STRUCT_W-1:0] out_struct;
    logic                out_valid;
    logic                out_ready;
    logic                err;
    logic [TAG_W-1:0]    err_field;
    logic                err_clear;
    logic [7:0]          fsm_state;

    modport master (
        output in_data, in_tag, in_valid, out_ready, err_clear,
        input  in_ready, out_struct, out_valid, err, err_field, fsm_state
    );

    modport slave (
        input  in_data, in_tag, in_valid, out_ready, err_clear,
        output in_ready, out_struct, out_valid, err, err_field, fsm_state
    );
endinterface

// File: rtl/vsharp_struct_assembler_fsm.sv
// Loads a struct one tagged field per transfer, checks each tag against the
// expected field index, then presents the whole struct on one wide output.
module vsharp_struct_assembler_fsm #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 3
) (
    input logic clk,
    input logic reset,
    vsharp_struct_assembler_fsm_if.slave bus
);
    localparam int TAG_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int STRUCT_W = FIELD_W * NUM_FIELDS;
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_FIELDS - 1);

    typedef enum logic [7:0] {
        ST_INITIAL = 8'd0,
        ST_LOAD    = 8'd1,
        ST_EMIT    = 8'd2,
        ST_ERROR   = 8'd3
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    idx_q;
    logic [STRUCT_W-1:0] stage_q;
    logic [STRUCT_W-1:0] out_struct_q;
    logic                err_q;
    logic [TAG_W-1:0]    err_field_q;

    logic                in_ready_c;
    logic                out_valid_c;
    logic                in_fire;
    logic                out_fire;
    logic                tag_ok;
    logic                last_field;
    logic [STRUCT_W-1:0] stage_merged;

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; ready depends only on state, never combinationally on valid.
    assign in_fire    = bus.in_valid && in_ready_c;
    assign out_fire   = out_valid_c && bus.out_ready;
    assign tag_ok     = (bus.in_tag == idx_q);
    assign last_field = (idx_q == LAST_IDX);

    // Staging contents as they will be once the current field is written.
    always_comb begin
        stage_merged = stage_q;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx_q == TAG_W'(k)) begin
                stage_merged[k*FIELD_W +: FIELD_W] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INITIAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INITIAL: state_d = ST_LOAD;
            ST_LOAD: begin
                if (in_fire) begin
                    if (!tag_ok) begin
                        state_d = ST_ERROR;
                    end else if (last_field) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    state_d = ST_LOAD;
                end
            end
            ST_ERROR: begin
                if (bus.err_clear) begin
                    state_d = ST_INITIAL;
                end
            end
            default: state_d = ST_INITIAL;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_LOAD: in_ready_c  = 1'b1;
            ST_EMIT: out_valid_c = 1'b1;
            default: begin
                in_ready_c  = 1'b0;
                out_valid_c = 1'b0;
            end
        endcase
    end

    // out_struct only updates on completion, so partial loads stay hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            stage_q      <= '0;
            out_struct_q <= '0;
            err_q        <= 1'b0;
            err_field_q  <= '0;
        end else begin
            case (state_q)
                ST_INITIAL: begin
                    idx_q   <= '0;
                    stage_q <= '0;
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        if (tag_ok) begin
                            stage_q <= stage_merged;
                            if (last_field) begin
                                out_struct_q <= stage_merged;
                                idx_q        <= '0;
                            end else begin
                                idx_q <= idx_q + TAG_W'(1);
                            end
                        end else begin
                            err_q       <= 1'b1;
                            err_field_q <= idx_q;
                        end
                    end
                end
                ST_ERROR: begin
                    if (bus.err_clear) begin
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    idx_q <= idx_q;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_struct = out_struct_q;
    assign bus.err        = err_q;
    assign bus.err_field  = err_field_q;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_vsharp_struct_assembler_fsm.sv
// Directed bench for the struct assembler: a 3x32 instance and a 1x8 instance.
module tb_vsharp_struct_assembler_fsm;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vsharp_struct_assembler_fsm_if #(.FIELD_W(32), .NUM_FIELDS(3)) bus3 ();
    vsharp_struct_assembler_fsm_if #(.FIELD_W(8),  .NUM_FIELDS(1)) bus1 ();

    vsharp_struct_assembler_fsm #(.FIELD_W(32), .NUM_FIELDS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    vsharp_struct_assembler_fsm #(.FIELD_W(8), .NUM_FIELDS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a field until the assembler accepts it, bounded to 20 cycles.
    task automatic send3(input logic [1:0] tag, input logic [31:0] data);
        bit acc;
        acc = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.in_tag   = tag;
        bus3.in_data  = data;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (bus3.in_ready) acc = 1'b1;
            tick();
        end
        bus3.in_valid = 1'b0;
        check("send_accepted", {127'd0, acc}, 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_tag = '0; bus3.in_data = '0;
        bus3.out_ready = 1'b0; bus3.err_clear = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_tag = '0; bus1.in_data = '0;
        bus1.out_ready = 1'b0; bus1.err_clear = 1'b0;
        tick();
        tick();
        check("rst_state",      bus3.fsm_state, 8'd0);
        check("rst_in_ready",   bus3.in_ready, 1'b0);
        check("rst_out_valid",  bus3.out_valid, 1'b0);
        check("rst_out_struct", bus3.out_struct, 96'd0);
        check("rst_err",        bus3.err, 1'b0);
        check("rst_err_field",  bus3.err_field, 2'd0);
        reset = 1'b0;

        // Basic assembly, fsm_state 0,1,1,1,2,1
        bus3.out_ready = 1'b1;
        bus3.in_valid = 1'b1; bus3.in_tag = 2'd0; bus3.in_data = 32'd123;
        check("t1_state0", bus3.fsm_state, 8'd0);
        check("t1_ready_initial", bus3.in_ready, 1'b0);
        tick();
        check("t1_state1", bus3.fsm_state, 8'd1);
        check("t1_ready_load", bus3.in_ready, 1'b1);
        tick();
        bus3.in_tag = 2'd1; bus3.in_data = 32'hDEADBEEF;
        check("t1_state2", bus3.fsm_state, 8'd1);
        tick();
        bus3.in_tag = 2'd2; bus3.in_data = 32'h1;
        check("t1_state3", bus3.fsm_state, 8'd1);
        check("t1_no_early_valid", bus3.out_valid, 1'b0);
        tick();
        bus3.in_valid = 1'b0;
        check("t1_state4", bus3.fsm_state, 8'd2);
        check("t1_out_valid", bus3.out_valid, 1'b1);
        check("t1_out_struct", bus3.out_struct, 96'h00000001_DEADBEEF_0000007B);
        tick();
        check("t1_state5", bus3.fsm_state, 8'd1);
        check("t1_valid_drop", bus3.out_valid, 1'b0);
        tick();
        check("t1_valid_once", bus3.out_valid, 1'b0);

        // Backpressure
        bus3.out_ready = 1'b0;
        send3(2'd0, 32'h11);
        send3(2'd1, 32'h22);
        send3(2'd2, 32'h33);
        bus3.in_valid = 1'b1; bus3.in_tag = 2'd0; bus3.in_data = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", bus3.out_valid, 1'b1);
            check("t2_hold_struct", bus3.out_struct, {32'h33, 32'h22, 32'h11});
            check("t2_hold_in_ready", bus3.in_ready, 1'b0);
            tick();
        end
        bus3.out_ready = 1'b1;
        check("t2_still_emit", bus3.fsm_state, 8'd2);
        tick();
        check("t2_after_hs_valid", bus3.out_valid, 1'b0);
        check("t2_after_hs_struct", bus3.out_struct, {32'h33, 32'h22, 32'h11});
        send3(2'd0, 32'hAA);
        send3(2'd1, 32'hBB);
        send3(2'd2, 32'hCC);
        check("t2_second_valid", bus3.out_valid, 1'b1);
        check("t2_second_struct", bus3.out_struct, {32'hCC, 32'hBB, 32'hAA});
        tick();

        // Tag mismatch from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send3(2'd0, 32'h5);
        send3(2'd2, 32'h7);
        check("t3_err", bus3.err, 1'b1);
        check("t3_err_field", bus3.err_field, 2'd1);
        check("t3_state", bus3.fsm_state, 8'd3);
        check("t3_in_ready", bus3.in_ready, 1'b0);
        check("t3_out_valid", bus3.out_valid, 1'b0);
        check("t3_out_struct", bus3.out_struct, 96'd0);
        tick();
        tick();
        check("t3_err_held", bus3.err, 1'b1);
        check("t3_state_held", bus3.fsm_state, 8'd3);
        bus3.err_clear = 1'b1;
        tick();
        bus3.err_clear = 1'b0;
        check("t3_clr_err", bus3.err, 1'b0);
        check("t3_clr_state", bus3.fsm_state, 8'd0);
        check("t3_clr_err_field", bus3.err_field, 2'd1);
        tick();
        check("t3_reload_state", bus3.fsm_state, 8'd1);
        bus3.err_clear = 1'b1;
        tick();
        bus3.err_clear = 1'b0;
        check("t3_clear_ignored", bus3.fsm_state, 8'd1);
        send3(2'd0, 32'h1);
        send3(2'd1, 32'h2);
        send3(2'd2, 32'h3);
        check("t3_new_valid", bus3.out_valid, 1'b1);
        check("t3_new_struct", bus3.out_struct, {32'h3, 32'h2, 32'h1});
        tick();

        // Asynchronous reset mid-load
        send3(2'd0, 32'h111);
        send3(2'd1, 32'h222);
        #2;
        reset = 1'b1;
        #1;
        check("t5_state", bus3.fsm_state, 8'd0);
        check("t5_in_ready", bus3.in_ready, 1'b0);
        check("t5_out_valid", bus3.out_valid, 1'b0);
        check("t5_out_struct", bus3.out_struct, 96'd0);
        check("t5_err", bus3.err, 1'b0);
        check("t5_err_field", bus3.err_field, 2'd0);
        tick();
        reset = 1'b0;
        send3(2'd0, 32'hA);
        send3(2'd1, 32'hB);
        check("t5_partial_valid", bus3.out_valid, 1'b0);
        check("t5_partial_struct", bus3.out_struct, 96'd0);
        send3(2'd2, 32'hC);
        check("t5_valid", bus3.out_valid, 1'b1);
        check("t5_struct", bus3.out_struct, {32'hC, 32'hB, 32'hA});
        tick();

        // Out-of-range tag
        send3(2'd3, 32'h9);
        check("t4_state", bus3.fsm_state, 8'd3);
        check("t4_err", bus3.err, 1'b1);
        check("t4_err_field", bus3.err_field, 2'd0);
        check("t4_out_struct", bus3.out_struct, {32'hC, 32'hB, 32'hA});
        bus3.err_clear = 1'b1;
        tick();
        bus3.err_clear = 1'b0;
        check("t4_clr_state", bus3.fsm_state, 8'd0);
        check("t4_clr_err", bus3.err, 1'b0);

        // Single-field instance
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_tag = 1'b0; bus1.in_data = 8'h11;
        check("t6_ready", bus1.in_ready, 1'b1);
        tick();
        bus1.in_data = 8'h22;
        check("t6_valid_a", bus1.out_valid, 1'b1);
        check("t6_struct_a", bus1.out_struct, 8'h11);
        check("t6_ready_emit", bus1.in_ready, 1'b0);
        tick();
        check("t6_gap_valid", bus1.out_valid, 1'b0);
        check("t6_gap_struct", bus1.out_struct, 8'h11);
        tick();
        bus1.in_valid = 1'b0;
        check("t6_valid_b", bus1.out_valid, 1'b1);
        check("t6_struct_b", bus1.out_struct, 8'h22);
        tick();
        check("t6_idle_valid", bus1.out_valid, 1'b0);
        bus1.in_valid = 1'b1; bus1.in_tag = 1'b1; bus1.in_data = 8'h55;
        tick();
        bus1.in_valid = 1'b0;
        check("t6_bad_state", bus1.fsm_state, 8'd3);
        check("t6_bad_err", bus1.err, 1'b1);
        check("t6_bad_err_field", bus1.err_field, 1'b0);
        check("t6_bad_struct", bus1.out_struct, 8'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
